// File: rtl/sdm_pkg.sv
// Shared constants for the sigma-delta modulator/decimator pair.
// Internal CIC width grows by CIC_N bits per octave of decimation.
package sdm_pkg;

  localparam int SDM_W = 4;
  localparam int CIC_N = 3;

  function automatic int cic_width(input int log2r);
    return SDM_W + CIC_N * log2r;
  endfunction

endpackage

// File: rtl/sdm_dec_comb.sv
// Three-stage CIC comb with delay registers and saturating output scaler.
// Loaded on the decimation tick; dout/dout_vld are registered one cycle after it.
module sdm_dec_comb
  import sdm_pkg::*;
#(
  parameter int W     = 10,
  parameter int LOG2R = 6
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 clr_i,
  input  logic                                 tick_i,
  input  logic                                 load_i,
  input  logic signed [cic_width(LOG2R)-1:0]   c0_i,
  output logic [W-1:0]                         dout_o,
  output logic                                 dout_vld_o
);

  localparam int B = cic_width(LOG2R);
  localparam int S = CIC_N * LOG2R - W;
  localparam logic signed [B-1:0] YMAX = B'((1 << W) - 1);

  logic signed [B-1:0] d1_q, d2_q, d3_q;
  logic signed [B-1:0] c1, c2, c3, y;
  logic [W-1:0]        dout_q, dout_d;
  logic                vld_q;

  // Differences wrap modulo 2^B; the true result always fits in B bits.
  assign c1 = c0_i - d1_q;
  assign c2 = c1 - d2_q;
  assign c3 = c2 - d3_q;
  assign y  = c3 >>> S;

  always_comb begin
    dout_d = y[W-1:0];
    if (y[B-1]) begin
      dout_d = '0;
    end else if (y > YMAX) begin
      dout_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d1_q   <= '0;
      d2_q   <= '0;
      d3_q   <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else if (clr_i) begin
      d1_q   <= '0;
      d2_q   <= '0;
      d3_q   <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (tick_i) begin
        d1_q <= c0_i;
        d2_q <= c1;
        d3_q <= c2;
        if (load_i) begin
          dout_q <= dout_d;
          vld_q  <= 1'b1;
        end
      end
    end
  end

  assign dout_o     = dout_q;
  assign dout_vld_o = vld_q;

endmodule

// File: rtl/sdm_dec.sv
// Third-order CIC decimator reconstructing W-bit samples from the 4-bit MASH stream.
// One output every 2^LOG2R enabled cycles after a three-tick warm-up; en=0 freezes all state.
module sdm_dec
  import sdm_pkg::*;
#(
  parameter int W     = 10,
  parameter int LOG2R = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic [SDM_W-1:0] sdm_in,
  output logic [W-1:0]     dout,
  output logic             dout_vld
);

  localparam int B = cic_width(LOG2R);

  logic signed [B-1:0] i1_q, i2_q, i3_q;
  logic signed [B-1:0] i1_d, i2_d, i3_d;
  logic signed [B-1:0] x_ext;
  logic [LOG2R-1:0]    cnt_q;
  logic [1:0]          wcnt_q;
  logic                tick, warm;

  assign x_ext = {{(B - SDM_W){sdm_in[SDM_W-1]}}, sdm_in};

  // Pipelined integrators: each stage sums the previous cycle's value of the one before.
  assign i1_d = i1_q + x_ext;
  assign i2_d = i2_q + i1_q;
  assign i3_d = i3_q + i2_q;

  assign tick = en && !clr && (cnt_q == '1);
  assign warm = (wcnt_q == 2'd3);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i1_q   <= '0;
      i2_q   <= '0;
      i3_q   <= '0;
      cnt_q  <= '0;
      wcnt_q <= '0;
    end else if (clr) begin
      i1_q   <= '0;
      i2_q   <= '0;
      i3_q   <= '0;
      cnt_q  <= '0;
      wcnt_q <= '0;
    end else if (en) begin
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      i3_q  <= i3_d;
      cnt_q <= cnt_q + LOG2R'(1);
      if (tick && !warm) begin
        wcnt_q <= wcnt_q + 2'd1;
      end
    end
  end

  sdm_dec_comb #(
    .W    (W),
    .LOG2R(LOG2R)
  ) u_comb (
    .clk       (clk),
    .rstn      (rstn),
    .clr_i     (clr),
    .tick_i    (tick),
    .load_i    (warm),
    .c0_i      (i3_q),
    .dout_o    (dout),
    .dout_vld_o(dout_vld)
  );

endmodule

// File: tb/tb_sdm_dec.sv
// Bench for sdm_dec: pattern table plus corner sequences, checked against a
// direct FIR-convolution model of the order-3 boxcar decimator.
module tb_sdm_dec;

  localparam int W     = 10;
  localparam int LOG2R = 6;
  localparam int R     = 1 << LOG2R;
  localparam int S     = 3 * LOG2R - W;
  localparam int HL    = 3 * R - 2;
  localparam int YMAX  = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rstn, en, clr;
  logic [3:0]   sdm_in;
  logic [W-1:0] dout;
  logic         dout_vld;

  always #5 clk = ~clk;

  sdm_dec #(.W(W), .LOG2R(LOG2R)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .clr     (clr),
    .sdm_in  (sdm_in),
    .dout    (dout),
    .dout_vld(dout_vld)
  );

  int vecs = 0;
  int errs = 0;
  int hist[$];
  int h[HL];
  int tbl_exp = -1;
  int pulses = 0;

  typedef struct {
    int pat[4];
    bit rnd_en;
    int nfr;
    int exp;
  } vec_t;

  vec_t tbl[10];

  // Impulse response of three cascaded length-R moving sums.
  function automatic void build_h();
    int a[HL];
    int b[HL];
    for (int i = 0; i < HL; i++) a[i] = (i < R) ? 1 : 0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < HL; i++) begin
        b[i] = 0;
        for (int j = 0; j < R; j++) if (i - j >= 0) b[i] += a[i - j];
      end
      a = b;
    end
    h = a;
  endfunction

  // Output for a tick at enabled cycle t; the integrator pipeline adds 3 cycles of delay.
  function automatic int model_out(int t);
    longint acc = 0;
    longint y;
    for (int k = 0; k < HL; k++) begin
      int idx = t - 3 - k;
      if (idx >= 0) acc += longint'(h[k]) * longint'(hist[idx]);
    end
    y = acc >>> S;
    if (y < 0) return 0;
    if (y > YMAX) return YMAX;
    return int'(y);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive at posedge+1, sample at the following posedge+1.
  task automatic cyc(input bit e, input bit c, input int x);
    bit pend = 1'b0;
    int ev = 0;
    int t;
    en = e; clr = c; sdm_in = 4'(x);
    if (c) begin
      hist.delete();
    end else if (e) begin
      t = hist.size();
      hist.push_back(x);
      if ((t % R) == R - 1 && (t / R) >= 3) begin
        pend = 1'b1;
        ev = model_out(t);
      end
    end
    @(posedge clk); #1;
    check("dout_vld", int'(dout_vld), int'(pend));
    if (pend) begin
      pulses++;
      check("dout_model", int'(dout), ev);
      if (tbl_exp >= 0) check("dout_table", int'(dout), tbl_exp);
    end
  endtask

  task automatic run_pat(input int p[4], input bit rnd_en, input int n_en);
    int k = 0;
    while (k < n_en) begin
      bit e = rnd_en ? bit'($urandom_range(0, 1)) : 1'b1;
      cyc(e, 1'b0, p[k % 4]);
      if (e) k++;
    end
  endtask

  initial begin
    int alt[4];
    int q1[4];
    int q3[4];
    int n;
    alt = '{0, 1, 0, 1};
    q1  = '{1, 0, 0, 0};
    q3  = '{1, 1, 1, 0};

    tbl[0] = '{pat: '{0, 1, 0, 1},     rnd_en: 1'b0, nfr: 6,  exp: 512};
    tbl[1] = '{pat: '{1, 1, 1, 1},     rnd_en: 1'b0, nfr: 6,  exp: 1023};
    tbl[2] = '{pat: '{-1, -1, -1, -1}, rnd_en: 1'b0, nfr: 6,  exp: 0};
    tbl[3] = '{pat: '{1, 0, 0, 0},     rnd_en: 1'b0, nfr: 6,  exp: 256};
    tbl[4] = '{pat: '{1, 1, 1, 0},     rnd_en: 1'b0, nfr: 6,  exp: 768};
    tbl[5] = '{pat: '{4, 4, 4, 4},     rnd_en: 1'b0, nfr: 40, exp: 1023};
    tbl[6] = '{pat: '{-8, -8, -8, -8}, rnd_en: 1'b0, nfr: 4,  exp: 0};
    tbl[7] = '{pat: '{7, 7, 7, 7},     rnd_en: 1'b0, nfr: 4,  exp: 1023};
    tbl[8] = '{pat: '{0, 1, 0, 1},     rnd_en: 1'b1, nfr: 6,  exp: 512};
    tbl[9] = '{pat: '{0, 0, 0, 0},     rnd_en: 1'b0, nfr: 3,  exp: 0};

    build_h();
    rstn = 1'b0; en = 1'b0; clr = 1'b0; sdm_in = '0;

    repeat (4) begin
      en = 1'b1;
      sdm_in = 4'($urandom);
      @(posedge clk); #1;
      check("rst_dout", int'(dout), 0);
      check("rst_vld", int'(dout_vld), 0);
    end
    rstn = 1'b1;
    hist.delete();

    tbl_exp = 0;
    pulses = 0;
    run_pat('{0, 0, 0, 0}, 1'b0, 6 * R);
    check("idle_pulses", pulses, 3);

    foreach (tbl[i]) begin
      tbl_exp = -1;
      cyc(1'b1, 1'b1, 0);
      tbl_exp = tbl[i].exp;
      pulses = 0;
      run_pat(tbl[i].pat, tbl[i].rnd_en, (4 + tbl[i].nfr) * R);
      check("tbl_pulses", pulses, tbl[i].nfr + 1);
    end

    // Quarter scale, then step to three-quarter scale.
    tbl_exp = -1;
    cyc(1'b1, 1'b1, 0);
    tbl_exp = 256;
    run_pat(q1, 1'b0, 6 * R);
    tbl_exp = -1;
    run_pat(q3, 1'b0, 2 * R);
    tbl_exp = 768;
    run_pat(q3, 1'b0, 5 * R);

    // Clear mid-frame: the partial frame is dropped, restart needs 4R enabled cycles.
    tbl_exp = -1;
    cyc(1'b1, 1'b1, 0);
    tbl_exp = 512;
    run_pat(alt, 1'b0, 4 * R + 20);
    cyc(1'b1, 1'b1, 0);
    n = 0;
    while (n < 5 * R) begin
      cyc(1'b1, 1'b0, alt[n % 4]);
      n++;
      if (dout_vld) break;
    end
    check("clr_gap", n, 4 * R);

    // Clear coinciding with a tick suppresses that output.
    run_pat(alt, 1'b0, 2 * R + (R - 1 - (hist.size() % R)));
    cyc(1'b1, 1'b1, 0);
    run_pat(alt, 1'b0, 5 * R);

    // Random samples, random enable, occasional clear.
    tbl_exp = -1;
    cyc(1'b1, 1'b1, 0);
    repeat (3000) begin
      bit e = ($urandom_range(0, 3) != 0);
      bit c = ($urandom_range(0, 599) == 0);
      int x = int'($signed(4'($urandom_range(0, 15))));
      if ($urandom_range(0, 1) == 1) x = $urandom_range(0, 2);
      cyc(e, c, x);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
